// File: rtl/spm_wb_ctrl_if.sv
// Wishbone slave bus bundle for the SPM register window.
// Handshake: a request is stb & cyc; the slave answers with a single-cycle
// ack one cycle after the request is first seen, with read data valid in that
// ack cycle. The master may keep stb high during the ack cycle without
// starting a second transfer.
interface spm_wb_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/spm_wb_ctrl.sv
// Wishbone register front-end for the serial-parallel multiplier (spm_top).
// Optional interrupt output and CTRL.IE bit are enabled by SPM_WB_CTRL_IRQ_EN.
module spm_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFE0
) (
  input  logic        clk,
  input  logic        rst_n,
  spm_wb_ctrl_if.slave wb,
  output logic [31:0] spm_mc,
  output logic [31:0] spm_mp,
  output logic        spm_start,
  input  logic        spm_done,
  input  logic [63:0] spm_prod,
  output logic [1:0]  dbg_state
`ifdef SPM_WB_CTRL_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic        ack_q;
  logic [31:0] dat_q;
  logic [31:0] mc, mp, prod_lo, prod_hi, cycles;
  logic        done, ovr, ie;

  logic        hit, req, wr, busy, ctrl_wr, go, fin;
  logic        done_w1c, ovr_set, ovr_w1c, done_nxt;
  logic [2:0]  off;
  logic [31:0] rd_data;
  logic        unused_adr;

  assign hit      = (wb.wbs_adr_i & ADDR_MASK) == BASE_ADDR;
  assign req      = wb.wbs_stb_i & wb.wbs_cyc_i & hit & ~ack_q;
  assign wr       = req & wb.wbs_we_i;
  assign off      = wb.wbs_adr_i[4:2];
  assign busy     = (state == S_BUSY);
  assign ctrl_wr  = wr & (off == 3'd2) & wb.wbs_sel_i[0];
  assign go       = ctrl_wr & wb.wbs_dat_i[0] & ~busy;
  assign fin      = busy & spm_done;
  assign done_w1c = ctrl_wr & wb.wbs_dat_i[2];
  assign ovr_w1c  = ctrl_wr & wb.wbs_dat_i[3];
  assign ovr_set  = busy & wr & ((off == 3'd0) | (off == 3'd1) |
                                 (ctrl_wr & wb.wbs_dat_i[0]));
  // A completing multiply sets DONE even if the same write tries to clear it.
  assign done_nxt = fin | (done & ~(done_w1c | go));
  assign unused_adr = ^wb.wbs_adr_i[1:0];

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign spm_mc       = mc;
  assign spm_mp       = mp;
  assign dbg_state    = state;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rd_data = 32'h0;
    case (off)
      3'd0: rd_data = mc;
      3'd1: rd_data = mp;
      3'd2: rd_data = {27'h0, ie, ovr, done, busy, 1'b0};
      3'd3: rd_data = prod_lo;
      3'd4: rd_data = prod_hi;
      3'd5: rd_data = cycles;
      default: rd_data = 32'h0;
    endcase
  end

`ifdef SPM_WB_CTRL_IRQ_EN
  logic ie_nxt;
  assign ie_nxt = ctrl_wr ? wb.wbs_dat_i[4] : ie;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      ie  <= ie_nxt;
      irq <= ie_nxt & done_nxt;
    end
  end
`else
  assign ie = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      spm_start <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= 32'h0;
      mc        <= 32'h0;
      mp        <= 32'h0;
      prod_lo   <= 32'h0;
      prod_hi   <= 32'h0;
      cycles    <= 32'h0;
      done      <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      ack_q <= req;
      if (req) dat_q <= rd_data;

      if (wr && !busy && off == 3'd0) mc <= merge_bytes(mc, wb.wbs_dat_i, wb.wbs_sel_i);
      if (wr && !busy && off == 3'd1) mp <= merge_bytes(mp, wb.wbs_dat_i, wb.wbs_sel_i);

      if (fin) begin
        prod_lo <= spm_prod[31:0];
        prod_hi <= spm_prod[63:32];
      end

      done <= done_nxt;

      if (ovr_set)      ovr <= 1'b1;
      else if (ovr_w1c) ovr <= 1'b0;

      // The count includes the cycle in which spm_done is seen.
      if (go)                                cycles <= 32'h0;
      else if (busy && cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;

      case (state)
        S_IDLE: begin
          if (go) begin
            state     <= S_BUSY;
            spm_start <= 1'b1;
          end
        end
        S_BUSY: begin
          if (spm_done) begin
            state     <= S_DONE;
            spm_start <= 1'b0;
          end
        end
        S_DONE: begin
          if (go) begin
            state     <= S_BUSY;
            spm_start <= 1'b1;
          end else if (done_w1c) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          spm_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spm_wb_ctrl.sv
// Directed self-checking bench for spm_wb_ctrl; the IRQ scenario runs only
// when built with SPM_WB_CTRL_IRQ_EN.
module tb_spm_wb_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] spm_mc, spm_mp;
  logic        spm_start;
  logic        spm_done = 1'b0;
  logic [63:0] spm_prod = 64'h0;
  logic [1:0]  dbg_state;
`ifdef SPM_WB_CTRL_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  spm_wb_ctrl_if bus ();

  spm_wb_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (bus.slave),
    .spm_mc    (spm_mc),
    .spm_mp    (spm_mp),
    .spm_start (spm_start),
    .spm_done  (spm_done),
    .spm_prod  (spm_prod),
    .dbg_state (dbg_state)
`ifdef SPM_WB_CTRL_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) if (spm_start) start_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata, output int acks);
    acks  = 0;
    rdata = 32'h0;
    @(negedge clk);
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    for (int i = 0; i < 8 && acks == 0; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        acks++;
        rdata = bus.wbs_dat_o;
      end
    end
    // Keep the strobe up through the cycle after ack: no second ack allowed.
    @(negedge clk);
    if (bus.wbs_ack_o) acks++;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_wr(input logic [4:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d;
    int a;
    wb_xfer(1'b1, BASE + 32'(off), dat, sel, d, a);
  endtask

  task automatic wb_rd(input logic [4:0] off, output logic [31:0] d);
    int a;
    wb_xfer(1'b0, BASE + 32'(off), 32'h0, 4'hF, d, a);
  endtask

  task automatic pulse_done(input logic [63:0] prod);
    @(negedge clk);
    spm_done = 1'b1;
    spm_prod = prod;
    @(negedge clk);
    spm_done = 1'b0;
    spm_prod = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", bus.wbs_ack_o); end
    n_checks++; if (bus.wbs_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h expected 0", bus.wbs_dat_o); end
    n_checks++; if (spm_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", spm_start); end
    n_checks++; if ({spm_mc, spm_mp} !== 64'h0) begin n_fail++; $display("FAIL reset_mc_mp: got %h %h expected 0 0", spm_mc, spm_mp); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wb_rd(5'h08, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", d); end
    wb_rd(5'h14, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_cycles: got %h expected 0", d); end
  endtask

  task automatic test_done_in_idle();
    logic [31:0] d;
    pulse_done(64'h1);
    wb_rd(5'h0C, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL idle_done_prod_lo: got %h expected 0", d); end
    wb_rd(5'h10, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL idle_done_prod_hi: got %h expected 0", d); end
    wb_rd(5'h08, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL idle_done_ctrl: got %h expected 0", d); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    wb_wr(5'h00, 32'h0, 4'hF);
    wb_wr(5'h00, 32'hAABB_CCDD, 4'b0010);
    wb_rd(5'h00, d);
    n_checks++; if (d !== 32'h0000_CC00) begin n_fail++; $display("FAIL mc_byte_lane: got %h expected 0000cc00", d); end
    wb_wr(5'h04, 32'h1234_5678, 4'b1001);
    wb_rd(5'h04, d);
    n_checks++; if (d !== 32'h1200_0078) begin n_fail++; $display("FAIL mp_byte_lane: got %h expected 12000078", d); end
  endtask

  task automatic test_multiply();
    logic [31:0] d;
    bit seen;
    wb_wr(5'h00, 32'd7, 4'hF);
    wb_wr(5'h04, 32'd6, 4'hF);
    n_checks++; if ({spm_mc, spm_mp} !== {32'd7, 32'd6}) begin n_fail++; $display("FAIL mc_mp_ports: got %0d %0d expected 7 6", spm_mc, spm_mp); end
    start_cnt = 0;
    wb_wr(5'h08, 32'h1, 4'h1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (start_cnt == 65) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL mul_wait_start: got start_cnt %0d expected 65 within bound", start_cnt); end
    spm_done = 1'b1;
    spm_prod = 64'd42;
    @(negedge clk);
    spm_done = 1'b0;
    spm_prod = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (2) @(negedge clk);
    n_checks++; if (start_cnt !== 66) begin n_fail++; $display("FAIL mul_start_len: got %0d expected 66", start_cnt); end
    n_checks++; if (spm_start !== 1'b0) begin n_fail++; $display("FAIL mul_start_drop: got %b expected 0", spm_start); end
    wb_rd(5'h08, d);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL mul_ctrl: got %h expected 4", d); end
    wb_rd(5'h0C, d);
    n_checks++; if (d !== 32'd42) begin n_fail++; $display("FAIL mul_prod_lo: got %h expected 2a", d); end
    wb_rd(5'h10, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mul_prod_hi: got %h expected 0", d); end
    wb_rd(5'h14, d);
    n_checks++; if (d !== 32'd66) begin n_fail++; $display("FAIL mul_cycles: got %0d expected 66", d); end
  endtask

  task automatic test_restart_and_race();
    logic [31:0] d;
    // From DONE: a new start enters BUSY and clears DONE at once.
    wb_wr(5'h08, 32'h1, 4'h1);
    wb_rd(5'h08, d);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL restart_ctrl: got %h expected 2", d); end
    n_checks++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL restart_state: got %0d expected 1", dbg_state); end
    // W1C of DONE in the same cycle spm_done arrives.
    @(negedge clk);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = BASE + 32'h08; bus.wbs_dat_i = 32'h4; bus.wbs_sel_i = 4'h1;
    spm_done = 1'b1;
    spm_prod = 64'h0000_0005_0000_0009;
    @(negedge clk);
    spm_done = 1'b0;
    spm_prod = 64'h0;
    n_checks++; if (bus.wbs_ack_o !== 1'b1) begin n_fail++; $display("FAIL race_ack: got %b expected 1", bus.wbs_ack_o); end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    wb_rd(5'h08, d);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL race_ctrl: got %h expected 4", d); end
    wb_rd(5'h10, d);
    n_checks++; if (d !== 32'h5) begin n_fail++; $display("FAIL race_prod_hi: got %h expected 5", d); end
    wb_rd(5'h0C, d);
    n_checks++; if (d !== 32'h9) begin n_fail++; $display("FAIL race_prod_lo: got %h expected 9", d); end
    wb_wr(5'h08, 32'h4, 4'h1);
    wb_rd(5'h08, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_done_ctrl: got %h expected 0", d); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL w1c_done_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_busy_overrun();
    logic [31:0] d;
    int a;
    wb_wr(5'h00, 32'd7, 4'hF);
    wb_wr(5'h08, 32'h1, 4'h1);
    wb_xfer(1'b1, BASE + 32'h08, 32'h1, 4'h1, d, a);
    n_checks++; if (a !== 1) begin n_fail++; $display("FAIL ovr_start_acks: got %0d expected 1", a); end
    wb_xfer(1'b1, BASE + 32'h00, 32'd5, 4'hF, d, a);
    n_checks++; if (a !== 1) begin n_fail++; $display("FAIL ovr_mc_acks: got %0d expected 1", a); end
    wb_rd(5'h00, d);
    n_checks++; if (d !== 32'd7) begin n_fail++; $display("FAIL ovr_mc_kept: got %0d expected 7", d); end
    wb_rd(5'h08, d);
    n_checks++; if (d !== 32'hA) begin n_fail++; $display("FAIL ovr_ctrl: got %h expected a", d); end
    pulse_done(64'd35);
    wb_rd(5'h08, d);
    n_checks++; if (d !== 32'hC) begin n_fail++; $display("FAIL ovr_done_ctrl: got %h expected c", d); end
    wb_wr(5'h08, 32'h8, 4'h1);
    wb_rd(5'h08, d);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL ovr_w1c: got %h expected 4", d); end
    wb_wr(5'h08, 32'h4, 4'h1);
    wb_rd(5'h08, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ovr_clear_all: got %h expected 0", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    int a;
    wb_xfer(1'b1, BASE + 32'h18, 32'hFFFF_FFFF, 4'hF, d, a);
    n_checks++; if (a !== 1) begin n_fail++; $display("FAIL unmapped_wr_acks: got %0d expected 1", a); end
    wb_rd(5'h18, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd18: got %h expected 0", d); end
    wb_rd(5'h1C, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd1c: got %h expected 0", d); end
    wb_xfer(1'b0, BASE + 32'h20, 32'h0, 4'hF, d, a);
    n_checks++; if (a !== 0) begin n_fail++; $display("FAIL out_of_window_acks: got %0d expected 0", a); end
`ifndef SPM_WB_CTRL_IRQ_EN
    wb_wr(5'h08, 32'h10, 4'h1);
    wb_rd(5'h08, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ie_absent: got %h expected 0", d); end
`endif
  endtask

`ifdef SPM_WB_CTRL_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    wb_wr(5'h08, 32'h11, 4'h1);
    @(negedge clk);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_busy: got %b expected 0", irq); end
    @(negedge clk);
    spm_done = 1'b1;
    @(negedge clk);
    spm_done = 1'b0;
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b expected 1", irq); end
    wb_rd(5'h08, d);
    n_checks++; if (d !== 32'h14) begin n_fail++; $display("FAIL irq_ctrl: got %h expected 14", d); end
    wb_wr(5'h08, 32'h14, 4'h1);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b expected 0", irq); end
  endtask
`endif

  task automatic test_reset_mid_busy();
    logic [31:0] d;
    wb_wr(5'h00, 32'd3, 4'hF);
    wb_wr(5'h04, 32'd9, 4'hF);
    wb_wr(5'h08, 32'h1, 4'h1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (spm_start !== 1'b0) begin n_fail++; $display("FAIL rst_busy_start: got %b expected 0", spm_start); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_busy_state: got %0d expected 0", dbg_state); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_done(64'hFFFF_0000_FFFF_0000);
    for (int i = 0; i < 6; i++) begin
      wb_rd(5'(4 * i), d);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_busy_reg%0d: got %h expected 0", i, d); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_done_in_idle();
    test_byte_lanes();
    test_multiply();
    test_restart_and_race();
    test_busy_overrun();
    test_unmapped();
`ifdef SPM_WB_CTRL_IRQ_EN
    test_irq();
`endif
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
